// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and small word/byte helpers
// used by the key schedule and the cipher datapath.
package aes_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam logic [3:0] AES_LAST_ROUND = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
        return {w[AES_WORD_W-9:0], w[AES_WORD_W-1 -: 8]};
    endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Request / round-key stream bundle between the round controller and the key schedule.
// master drives start/key_in/rk_ready, slave returns the round-key stream and status.
interface key_schedule_if;
    import aes_pkg::*;

    logic                 start;
    logic [AES_KEY_W-1:0] key_in;
    logic                 rk_ready;
    logic                 rk_valid;
    logic [AES_KEY_W-1:0] round_key;
    logic [3:0]           round_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, round_key, round_idx, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, round_key, round_idx, busy, done
    );

endinterface

// File: rtl/key_schedule_sub_word.sv
// AES byte S-box and the 32-bit SubWord built from four of them.
// Purely combinational, zero latency, no flow control.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);
    // One 128-bit constant per high nibble; byte 0 of each row sits in the MSBs.
    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] row;
    logic [6:0]   bit_sel;

    assign row     = SBOX_ROWS[value[7:4]];
    // Column c lives at bit offset 8*(15-c), and 15-c equals ~c for a nibble.
    assign bit_sel = {~value[3:0], 3'b000};
    assign subst   = row[bit_sel +: 8];

endmodule

module sub_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] word,
    output logic [AES_WORD_W-1:0] sub
);
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .value (word[8*i +: 8]),
            .subst (sub[8*i +: 8])
        );
    end

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one per rk_valid/rk_ready handshake.
// Round 0 one cycle after start; stalls hold key/index/valid stable; all outputs registered.
module key_schedule
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    key_schedule_if.slave ks
);
    ks_state_t state, state_nxt;

    logic [AES_KEY_W-1:0] rk_q, rk_d;
    logic [3:0]           idx_q, idx_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [AES_WORD_W-1:0] w0, w1, w2, w3;
    logic [AES_WORD_W-1:0] rot_w3, sub_w3, t_word;
    logic [AES_WORD_W-1:0] n0, n1, n2, n3;
    logic                  handshake, last_round;

    assign {w0, w1, w2, w3} = rk_q;
    assign rot_w3 = rot_word(w3);

    sub_word u_sub_word (
        .word (rot_w3),
        .sub  (sub_w3)
    );

    // Next-key chain is combinational from the registered key so one key per cycle is possible.
    assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    assign handshake  = vld_q & ks.rk_ready;
    assign last_round = (idx_q == AES_LAST_ROUND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ks.start) state_nxt = GEN;
            GEN:     if (handshake && last_round) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rk_d   = rk_q;
        idx_d  = idx_q;
        rcon_d = rcon_q;
        vld_d  = vld_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state)
            IDLE: begin
                if (ks.start) begin
                    rk_d   = ks.key_in;
                    idx_d  = 4'd0;
                    rcon_d = 8'h01;
                    vld_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            GEN: begin
                if (handshake) begin
                    if (last_round) begin
                        vld_d  = 1'b0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        rk_d   = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: begin
                vld_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_q   <= '0;
            idx_q  <= 4'd0;
            rcon_q <= 8'h01;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rk_q   <= rk_d;
            idx_q  <= idx_d;
            rcon_q <= rcon_d;
            vld_q  <= vld_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign ks.rk_valid  = vld_q;
    assign ks.round_key = rk_q;
    assign ks.round_idx = idx_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;

endmodule

// File: doc/key_schedule.md
# key_schedule

Iterative AES-128 key expansion engine that feeds the cipher's AddRoundKey stage. It turns a 128-bit cipher key into the 11 round keys (round 0..10), one key per accepted handshake. It computes SubWord with four instances of the existing byte S-box. A valid/ready output handshake lets the round datapath stall the schedule.

## Interface
Parameters: none (AES-128 only).

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request expansion; sampled only while idle
- key_in  input  128  cipher key; byte 0 in [127:120]; sampled on accepted start
- rk_ready  input  1  consumer accepts current round key
- rk_valid  output  1  round_key/round_idx valid
- round_key  output  128  current round key, word w[4r] in [127:96]
- round_idx  output  4  round number 0..10 of round_key
- busy  output  1  expansion in progress (state GEN)
- done  output  1  one-cycle pulse after round 10 accepted

## Operation
- States: IDLE, GEN.
- IDLE: busy=0, rk_valid=0. If start=1, latch key_in into round_key, set round_idx=0, rcon=8'h01, rk_valid=1 and go to GEN.
- GEN: busy=1, rk_valid=1.
  - Handshake occurs in a cycle with rk_valid=1 and rk_ready=1.
  - On handshake with round_idx<10, load the next key, round_idx+1, and rcon=xtime(rcon).
  - On handshake with round_idx=10, go to IDLE, rk_valid=0, done=1 for the next cycle only.
- Next key from current words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - RotWord({a,b,c,d}) = {b,c,d,a}
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Without a handshake, round_key, round_idx and rk_valid hold stable (no change while stalled).
- start while busy=1 is ignored. key_in changes after acceptance have no effect.
- start in the same cycle as done=1 (state IDLE) is accepted normally.
- The rcon register is internal and never exposed.

## Timing
- Reset values: rk_valid=0, busy=0, done=0, round_key=0, round_idx=0, rcon=8'h01, state IDLE.
- Reset mid-expansion aborts at the next edge: outputs take reset values and no done pulse is issued.
- Latency: start accepted at edge T gives round 0 valid after T.
- With rk_ready held at 1, round r is presented in cycle T+1+r. Round 10 is in cycle T+11, done=1 in cycle T+12.
- Throughput: one round key per cycle. The SubWord/XOR path is combinational from registered w3 within one cycle.
- busy rises with rk_valid and falls in the cycle done pulses.
- rk_valid never depends combinationally on rk_ready. All outputs are registered.

## Structure
- Shared package aes_pkg holds:
  - constants AES_KEY_W=128, AES_WORD_W=32, AES_LAST_ROUND=4'd10
  - the function xtime
  - the function rot_word
  - the FSM state typedef (IDLE, GEN)
- One sub-module, sub_word: 32-bit combinational SubWord built from four byte S-box instances. The cipher datapath can reuse it.
- key_schedule contains the FSM, round counter, rcon register, round-key register and next-key XOR chain.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 10 at T+11, done at T+12
- All-zero key:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Backpressure: drop rk_ready for 3 cycles at round 4.
  - round_key, round_idx=4 and rk_valid hold stable.
  - Final keys match the unstalled run, done delayed by 3 cycles.
- start pulsed with a different key at round 6: ignored, and all keys match the original key.
- start asserted in the done cycle: a new expansion begins, with round 0 valid on the next cycle.
- rst_n low for one cycle at round 7:
  - next cycle rk_valid=0, busy=0, round_idx=0, round_key=0, no done pulse.
  - A following start restarts cleanly from rcon=01.
